// File: rtl/tt_vec_ipkg.sv
// tt_vec_ipkg: shared definitions for the integer add/sub/saturate/average vector unit.
//   tt_op_e  : opcode encoding carried on i_op_0a
//   SEW_*    : element width encoding carried on i_vsew_0a
//   VXRM_*   : fixed-point rounding mode encoding carried on i_vxrm_0a
//   rnd_bit  : rounding increment applied after the averaging right shift
package tt_vec_ipkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SADDU = 4'd2,
    OP_SADD  = 4'd3,
    OP_SSUBU = 4'd4,
    OP_SSUB  = 4'd5,
    OP_AADDU = 4'd6,
    OP_AADD  = 4'd7,
    OP_ASUBU = 4'd8,
    OP_ASUB  = 4'd9
  } tt_op_e;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  localparam logic [1:0] VXRM_RNU = 2'd0;
  localparam logic [1:0] VXRM_RNE = 2'd1;
  localparam logic [1:0] VXRM_RDN = 2'd2;
  localparam logic [1:0] VXRM_ROD = 2'd3;

  // v1/v0 are bits [1:0] of the unshifted SEW+1-bit intermediate.
  function automatic logic rnd_bit(input logic [1:0] vxrm, input logic v1, input logic v0);
    logic r;
    case (vxrm)
      VXRM_RNU: r = v0;
      VXRM_RNE: r = v0 & v1;
      VXRM_RDN: r = 1'b0;
      VXRM_ROD: r = v0 & ~v1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tt_vec_iaddsat_lane64.sv
// tt_vec_iaddsat_lane64: combinational element arithmetic for one 64-bit slice.
//   i_op/i_vsew/i_vxrm : opcode, element width, rounding mode
//   i_src1/i_src2      : operands (result = src2 op src1)
//   i_src3             : old destination, passed through for masked-off elements
//   i_mask             : bit e enables slice element e under the current width
//   o_res/o_sat        : slice result, OR of saturation over active elements
// All four element widths are computed in parallel and muxed by i_vsew, so no
// carry ever leaves the slice.
module tt_vec_iaddsat_lane64
  import tt_vec_ipkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_vsew,
  input  logic [1:0]  i_vxrm,
  input  logic [63:0] i_src1,
  input  logic [63:0] i_src2,
  input  logic [63:0] i_src3,
  input  logic [7:0]  i_mask,
  output logic [63:0] o_res,
  output logic        o_sat
);

  tt_op_e w_op;
  logic   w_sub, w_signed, w_satop, w_avg;

  assign w_op = tt_op_e'(i_op);

  always_comb begin
    w_sub    = 1'b0;
    w_signed = 1'b0;
    w_satop  = 1'b0;
    w_avg    = 1'b0;
    case (w_op)
      OP_ADD:   ;
      OP_SUB:   w_sub = 1'b1;
      OP_SADDU: w_satop = 1'b1;
      OP_SADD:  begin w_satop = 1'b1; w_signed = 1'b1; end
      OP_SSUBU: begin w_satop = 1'b1; w_sub = 1'b1; end
      OP_SSUB:  begin w_satop = 1'b1; w_sub = 1'b1; w_signed = 1'b1; end
      OP_AADDU: w_avg = 1'b1;
      OP_AADD:  begin w_avg = 1'b1; w_signed = 1'b1; end
      OP_ASUBU: begin w_avg = 1'b1; w_sub = 1'b1; end
      OP_ASUB:  begin w_avg = 1'b1; w_sub = 1'b1; w_signed = 1'b1; end
      default:  ;
    endcase
  end

  logic [3:0][63:0] w_res_sew;
  logic [3:0]       w_sat_sew;

  for (genvar g = 0; g < 4; g++) begin : g_sew
    localparam int W = 8 << g;
    localparam int N = 8 >> g;
    logic [63:0]  w_res_g;
    logic [N-1:0] w_sat_g;

    for (genvar e = 0; e < N; e++) begin : g_el
      logic [W-1:0] w_a, w_b, w_c, w_y;
      logic [W+1:0] w_ea, w_eb, w_v;
      logic         w_r, w_s;

      assign w_a  = i_src1[e*W +: W];
      assign w_b  = i_src2[e*W +: W];
      assign w_c  = i_src3[e*W +: W];
      // Two guard bits: the exact sum/difference of two W-bit values always fits.
      assign w_ea = w_signed ? {{2{w_a[W-1]}}, w_a} : {2'b00, w_a};
      assign w_eb = w_signed ? {{2{w_b[W-1]}}, w_b} : {2'b00, w_b};
      assign w_v  = w_sub ? (w_eb - w_ea) : (w_eb + w_ea);
      assign w_r  = rnd_bit(i_vxrm, w_v[1], w_v[0]);

      always_comb begin
        w_y = w_v[W-1:0];
        w_s = 1'b0;
        if (w_avg) begin
          w_y = w_v[W:1] + {{(W-1){1'b0}}, w_r};
        end else if (w_satop) begin
          if (w_signed) begin
            // Signed overflow: the W+1-bit sign differs from the W-bit sign.
            if (w_v[W] != w_v[W-1]) begin
              w_s = 1'b1;
              w_y = w_v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
          end else if (w_sub) begin
            if (w_v[W+1]) begin
              w_s = 1'b1;
              w_y = '0;
            end
          end else if (w_v[W]) begin
            w_s = 1'b1;
            w_y = '1;
          end
        end
        if (!i_mask[e]) begin
          w_y = w_c;
          w_s = 1'b0;
        end
      end

      assign w_res_g[e*W +: W] = w_y;
      assign w_sat_g[e]        = w_s;
    end

    assign w_res_sew[g] = w_res_g;
    assign w_sat_sew[g] = |w_sat_g;
  end

  always_comb begin
    o_res = w_res_sew[0];
    o_sat = w_sat_sew[0];
    case (i_vsew)
      SEW_8:  begin o_res = w_res_sew[0]; o_sat = w_sat_sew[0]; end
      SEW_16: begin o_res = w_res_sew[1]; o_sat = w_sat_sew[1]; end
      SEW_32: begin o_res = w_res_sew[2]; o_sat = w_sat_sew[2]; end
      SEW_64: begin o_res = w_res_sew[3]; o_sat = w_sat_sew[3]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tt_vec_iaddsat_pipe.sv
// tt_vec_iaddsat_pipe: pipelined vector integer add/sub with saturating and
// averaging forms, elastic valid/ready on both ends, sticky vxsat.
//   i_clk, i_reset_n                 : clock, synchronous active-low reset
//   i_vld_0a/o_rdy_0a                : issue handshake
//   i_op_0a/i_vsew_0a/i_vxrm_0a      : opcode, element width, rounding mode
//   i_src1_0a/i_src2_0a/i_src3_0a    : operands, src3 = old destination
//   i_mask_0a/i_usemask_0a           : element mask and its enable
//   i_flush                          : drop everything in flight
//   o_vld_Na/i_rdy_Na                : result handshake
//   o_data_Na/o_sat_Na               : result and its saturation flag
//   o_vxsat/i_vxsat_clr              : sticky saturation flag and its clear
// Arithmetic is done ahead of stage 0; stages 1..LAT-1 only hold/retime.
module tt_vec_iaddsat_pipe
  import tt_vec_ipkg::*;
#(
  parameter int VLEN = 256,
  parameter int LAT  = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_vld_0a,
  output logic              o_rdy_0a,
  input  logic [3:0]        i_op_0a,
  input  logic [1:0]        i_vsew_0a,
  input  logic [1:0]        i_vxrm_0a,
  input  logic [VLEN-1:0]   i_src1_0a,
  input  logic [VLEN-1:0]   i_src2_0a,
  input  logic [VLEN-1:0]   i_src3_0a,
  input  logic [VLEN/8-1:0] i_mask_0a,
  input  logic              i_usemask_0a,
  input  logic              i_flush,
  output logic              o_vld_Na,
  input  logic              i_rdy_Na,
  output logic [VLEN-1:0]   o_data_Na,
  output logic              o_sat_Na,
  output logic              o_vxsat,
  input  logic              i_vxsat_clr
);

  localparam int NLANE = VLEN / 64;
  localparam int MW    = VLEN / 8;

  logic [MW-1:0]    w_mask_eff;
  logic [VLEN-1:0]  w_res;
  logic [NLANE-1:0] w_lane_sat;

  assign w_mask_eff = i_usemask_0a ? i_mask_0a : '1;

  // Each slice gets the mask bits of its own elements, which depend on the width.
  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    logic [7:0] w_lmask;
    always_comb begin
      w_lmask = 8'h00;
      case (i_vsew_0a)
        SEW_8:  w_lmask = w_mask_eff[8*l +: 8];
        SEW_16: w_lmask = {4'h0, w_mask_eff[4*l +: 4]};
        SEW_32: w_lmask = {6'h00, w_mask_eff[2*l +: 2]};
        SEW_64: w_lmask = {7'h00, w_mask_eff[l]};
        default: ;
      endcase
    end

    tt_vec_iaddsat_lane64 u_lane (
      .i_op   (i_op_0a),
      .i_vsew (i_vsew_0a),
      .i_vxrm (i_vxrm_0a),
      .i_src1 (i_src1_0a[64*l +: 64]),
      .i_src2 (i_src2_0a[64*l +: 64]),
      .i_src3 (i_src3_0a[64*l +: 64]),
      .i_mask (w_lmask),
      .o_res  (w_res[64*l +: 64]),
      .o_sat  (w_lane_sat[l])
    );
  end

  logic [LAT-1:0]  r_vld;
  logic [LAT-1:0]  r_sat;
  logic [VLEN-1:0] r_data [LAT];
  logic            r_vxsat;

  // w_go[i]: stage i may take new content this cycle (empty or draining).
  logic [LAT-1:0]  w_go;
  logic [LAT-1:0]  w_in_vld;
  logic [LAT-1:0]  w_in_sat;
  logic [VLEN-1:0] w_in_data [LAT];
  logic            w_acc;
  logic            w_out_hs;

  assign w_go[LAT-1] = ~r_vld[LAT-1] | i_rdy_Na;
  for (genvar g = 0; g < LAT - 1; g++) begin : g_go
    assign w_go[g] = ~r_vld[g] | w_go[g+1];
  end

  assign o_rdy_0a = i_reset_n & ~i_flush & w_go[0];
  assign w_acc    = i_vld_0a & o_rdy_0a;

  assign w_in_vld[0]  = w_acc;
  assign w_in_sat[0]  = |w_lane_sat;
  assign w_in_data[0] = w_res;
  for (genvar g = 1; g < LAT; g++) begin : g_chain
    assign w_in_vld[g]  = r_vld[g-1];
    assign w_in_sat[g]  = r_sat[g-1];
    assign w_in_data[g] = r_data[g-1];
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LAT; i++) begin
      if (w_go[i] && w_in_vld[i]) begin
        r_data[i] <= w_in_data[i];
        r_sat[i]  <= w_in_sat[i];
      end
    end
    if (!i_reset_n) begin
      r_vld          <= '0;
      r_data[LAT-1]  <= '0;
      r_sat[LAT-1]   <= 1'b0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (w_go[i]) r_vld[i] <= w_in_vld[i];
      end
    end
  end

  // A result leaving during a flush is not counted toward vxsat.
  assign w_out_hs = o_vld_Na & i_rdy_Na & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                   r_vxsat <= 1'b0;
    else if (w_out_hs && r_sat[LAT-1]) r_vxsat <= 1'b1;
    else if (i_vxsat_clr)             r_vxsat <= 1'b0;
  end

  assign o_vld_Na  = i_reset_n & r_vld[LAT-1];
  assign o_sat_Na  = o_vld_Na & r_sat[LAT-1];
  assign o_data_Na = i_reset_n ? r_data[LAT-1] : '0;
  assign o_vxsat   = r_vxsat;

endmodule
